// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared ALU.
// Two requesters, registered ALU inputs, per-port response capture.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,

    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,

    output logic             rsp_valid0,
    output logic [WIDTH-1:0] rsp_out0,
    output logic             rsp_zero0,
    output logic             rsp_equal0,

    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_out1,
    output logic             rsp_zero1,
    output logic             rsp_equal1,

    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_equal,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;

    logic   window;
    logic   grant0;
    logic   grant1;
    logic   accept;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        window = (state == IDLE) || (state == RESP);
        grant0 = req_valid0 && (!req_valid1 || last_grant);
        grant1 = req_valid1 && (!req_valid0 || !last_grant);
    end

    assign req_ready0 = window && grant0;
    assign req_ready1 = window && grant1;
    assign accept     = req_ready0 || req_ready1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid0 <= 1'b0;
            rsp_out0   <= '0;
            rsp_zero0  <= 1'b0;
            rsp_equal0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_out1   <= '0;
            rsp_zero1  <= 1'b0;
            rsp_equal1 <= 1'b0;
        end else begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state      <= EXEC;
                        busy       <= 1'b1;
                        owner      <= grant1;
                        last_grant <= grant1;
                        alu_op     <= grant1 ? req_op1 : req_op0;
                        alu_a      <= grant1 ? req_a1  : req_a0;
                        alu_b      <= grant1 ? req_b1  : req_b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                EXEC: begin
                    state <= RESP;
                    busy  <= 1'b0;
                    // Only the owner's response registers see the capture.
                    if (owner) begin
                        rsp_valid1 <= 1'b1;
                        rsp_out1   <= alu_out;
                        rsp_zero1  <= alu_zero;
                        rsp_equal1 <= alu_equal;
                    end else begin
                        rsp_valid0 <= 1'b1;
                        rsp_out0   <= alu_out;
                        rsp_zero0  <= alu_zero;
                        rsp_equal0 <= alu_equal;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU stub.
// Directed vectors carry hand-computed results.
module tb_alu_arbiter;

    localparam int W = 16;

    logic         clk;
    logic         reset_n;
    logic         req_valid0, req_ready0;
    logic [1:0]   req_op0;
    logic [W-1:0] req_a0, req_b0;
    logic         req_valid1, req_ready1;
    logic [1:0]   req_op1;
    logic [W-1:0] req_a1, req_b1;
    logic         rsp_valid0, rsp_zero0, rsp_equal0;
    logic [W-1:0] rsp_out0;
    logic         rsp_valid1, rsp_zero1, rsp_equal1;
    logic [W-1:0] rsp_out1;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_zero, alu_equal;
    logic         busy;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid0 (req_valid0),
        .req_ready0 (req_ready0),
        .req_op0    (req_op0),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_valid1 (req_valid1),
        .req_ready1 (req_ready1),
        .req_op1    (req_op1),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid0 (rsp_valid0),
        .rsp_out0   (rsp_out0),
        .rsp_zero0  (rsp_zero0),
        .rsp_equal0 (rsp_equal0),
        .rsp_valid1 (rsp_valid1),
        .rsp_out1   (rsp_out1),
        .rsp_zero1  (rsp_zero1),
        .rsp_equal1 (rsp_equal1),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_equal  (alu_equal),
        .busy       (busy)
    );

    assign alu_out   = (alu_op == 2'd0) ? alu_a + alu_b : alu_a - alu_b;
    assign alu_zero  = (alu_out == '0);
    assign alu_equal = (alu_a == alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         zero;
        logic         equal;
    } vec_t;

    typedef struct {
        logic         port;
        logic [W-1:0] out;
        logic         zero;
        logic         equal;
        int           cyc;
    } exp_t;

    vec_t q0[$];
    vec_t q1[$];
    int   gq[$];
    exp_t sbq[$];

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] out,
                                input logic zero, input logic equal);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.out = out; v.zero = zero; v.equal = equal;
        return v;
    endfunction

    // Monitor: pops the scoreboard on every response pulse.
    exp_t e;
    always @(negedge clk) begin
        if (rsp_valid0 || rsp_valid1) begin
            check("rsp_onehot", {31'd0, rsp_valid0 & rsp_valid1}, 0);
            if (sbq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_rsp: valid0=%b valid1=%b, expected none",
                         rsp_valid0, rsp_valid1);
            end else begin
                e = sbq.pop_front();
                check("rsp_port", {31'd0, rsp_valid1}, {31'd0, e.port});
                check("rsp_latency", cyc - e.cyc, 2);
                if (e.port) begin
                    check("rsp_out1", {16'd0, rsp_out1}, {16'd0, e.out});
                    check("rsp_zero1", {31'd0, rsp_zero1}, {31'd0, e.zero});
                    check("rsp_equal1", {31'd0, rsp_equal1}, {31'd0, e.equal});
                end else begin
                    check("rsp_out0", {16'd0, rsp_out0}, {16'd0, e.out});
                    check("rsp_zero0", {31'd0, rsp_zero0}, {31'd0, e.zero});
                    check("rsp_equal0", {31'd0, rsp_equal0}, {31'd0, e.equal});
                end
            end
        end
    end

    // After an accept the old operands are replaced by junk.
    task automatic apply();
        req_valid0 = (q0.size() > 0);
        req_valid1 = (q1.size() > 0);
        if (q0.size() > 0) begin
            req_op0 = q0[0].op; req_a0 = q0[0].a; req_b0 = q0[0].b;
        end else begin
            req_op0 = 2'd3; req_a0 = 16'hDEAD; req_b0 = 16'hBEEF;
        end
        if (q1.size() > 0) begin
            req_op1 = q1[0].op; req_a1 = q1[0].a; req_b1 = q1[0].b;
        end else begin
            req_op1 = 2'd3; req_a1 = 16'hCAFE; req_b1 = 16'hF00D;
        end
    endtask

    task automatic drive_all(input int budget);
        int   n;
        int   last;
        bit   have;
        logic p;
        exp_t x;
        vec_t v;
        n = 0; last = 0; have = 0;
        @(posedge clk);
        #1;
        apply();
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
            check("busy", {31'd0, busy}, {31'd0, (have && cyc == last + 1)});
            check("ready_onehot", {31'd0, req_ready0 & req_ready1}, 0);
            if (req_ready0 || req_ready1) begin
                p = req_ready1;
                if (gq.size() > 0) check("grant", {31'd0, p}, gq.pop_front());
                if (have) check("accept_gap", cyc - last, 2);
                have = 1;
                last = cyc;
                if ((p && q1.size() == 0) || (!p && q0.size() == 0)) begin
                    nvec++;
                    nfail++;
                    $display("FAIL ready_no_valid: port %0d ready without request", p);
                end else begin
                    v = p ? q1[0] : q0[0];
                    x.port = p; x.out = v.out; x.zero = v.zero;
                    x.equal = v.equal; x.cyc = cyc;
                    sbq.push_back(x);
                    @(posedge clk);
                    #1;
                    if (p) void'(q1.pop_front());
                    else   void'(q0.pop_front());
                    apply();
                end
            end
        end
        check("drain", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        gq.delete();
        apply();
        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req_valid0 = 1'b1; req_op0 = 2'd0; req_a0 = 16'h1111; req_b0 = 16'h2222;
        req_valid1 = 1'b1; req_op1 = 2'd1; req_a1 = 16'h3333; req_b1 = 16'h4444;
        #12;
        check("reset_ready0", {31'd0, req_ready0}, 1);
        check("reset_ready1", {31'd0, req_ready1}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rsp_valid", {30'd0, rsp_valid1, rsp_valid0}, 0);
        check("reset_alu_a", {16'd0, alu_a}, 0);
        check("reset_alu_b", {16'd0, alu_b}, 0);
        check("reset_alu_op", {30'd0, alu_op}, 0);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        #1 reset_n = 1'b1;

        // Single request on port 0
        q0.push_back(mk(2'd0, 16'h0004, 16'h0004, 16'h0008, 1'b0, 1'b1));
        gq.push_back(0);
        drive_all(20);

        // Zero flag on port 1; port 0 capture must hold
        q1.push_back(mk(2'd1, 16'h0004, 16'h0004, 16'h0000, 1'b1, 1'b1));
        gq.push_back(1);
        drive_all(20);
        check("hold_out0", {16'd0, rsp_out0}, 32'h0008);
        check("hold_zero0", {31'd0, rsp_zero0}, 0);
        check("hold_equal0", {31'd0, rsp_equal0}, 1);

        // Contention: grants alternate starting with port 0
        q0.push_back(mk(2'd0, 16'h0004, 16'h0003, 16'h0007, 1'b0, 1'b0));
        q0.push_back(mk(2'd1, 16'h0004, 16'h0003, 16'h0001, 1'b0, 1'b0));
        q1.push_back(mk(2'd1, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0));
        q1.push_back(mk(2'd0, 16'h0010, 16'h0001, 16'h0011, 1'b0, 1'b0));
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        drive_all(40);

        // Back-to-back on port 0, including wrap and zero results
        q0.push_back(mk(2'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0));
        q0.push_back(mk(2'd1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0));
        q0.push_back(mk(2'd1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b1));
        q0.push_back(mk(2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0));
        gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(0);
        drive_all(40);
        check("hold_out1", {16'd0, rsp_out1}, 32'h0011);

        // Reset during EXEC discards the in-flight result
        @(posedge clk);
        #1;
        req_valid1 = 1'b1; req_op1 = 2'd0; req_a1 = 16'h0001; req_b1 = 16'h0002;
        @(negedge clk);
        check("midrst_ready1", {31'd0, req_ready1}, 1);
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        check("midrst_busy_exec", {31'd0, busy}, 1);
        check("midrst_alu_a", {16'd0, alu_a}, 32'h0001);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_alu_a0", {16'd0, alu_a}, 0);
        check("midrst_alu_b0", {16'd0, alu_b}, 0);
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_busy", {31'd0, busy}, 0);
        check("post_rsp_valid", {30'd0, rsp_valid1, rsp_valid0}, 0);
        check("post_out0", {16'd0, rsp_out0}, 0);
        check("post_out1", {16'd0, rsp_out1}, 0);
        check("post_flags", {28'd0, rsp_zero0, rsp_equal0, rsp_zero1, rsp_equal1}, 0);
        check("post_sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 16-bit ALU in the single-cycle CPU datapath. It accepts operation requests (opcode plus two operands) from two requesters over a valid/ready handshake and grants the ALU round-robin. It drives registered operands into the ALU and captures OUT/ZERO/EQUAL into per-requester response registers. A one-cycle response pulse returns the result to the requester that issued the operation.

## Interface
- WIDTH, 16, operand/result width; OP is fixed at 2 bits.

- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID0 / REQ_VALID1  in  1  request present on port 0 / 1.
- REQ_READY0 / REQ_READY1  out  1  request accepted at this edge if VALID also high.
- REQ_OP0 / REQ_OP1  in  2  ALU opcode.
- REQ_A0 / REQ_A1, REQ_B0 / REQ_B1  in  WIDTH  operands.
- RSP_VALID0 / RSP_VALID1  out  1  one-cycle result pulse.
- RSP_OUT0 / RSP_OUT1  out  WIDTH  captured ALU OUT.
- RSP_ZERO0 / RSP_ZERO1, RSP_EQUAL0 / RSP_EQUAL1  out  1  captured ALU flags.
- ALU_OP  out  2  to ALU OP.
- ALU_A, ALU_B  out  WIDTH  to ALU INPUTA / INPUTB.
- ALU_OUT  in  WIDTH  from ALU OUT.
- ALU_ZERO, ALU_EQUAL  in  1  from ALU ZERO / EQUAL.
- BUSY  out  1  high in EXEC state.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Acceptance window is IDLE or RESP. A grant happens when at least one REQ_VALID is high.
- Only the granted port sees READY=1. READY is 0 on both ports in EXEC.
- Round-robin: LAST_GRANT register, reset value 1, so port 0 wins the first tie.
  - Both valid: grant the port other than LAST_GRANT.
  - One valid: grant it.
  - LAST_GRANT updates on each accept.
- On accept:
  - REQ_OPg, REQ_Ag and REQ_Bg are latched into the ALU_OP/ALU_A/ALU_B registers.
  - The owner bit records g.
  - State goes to EXEC.
- EXEC → RESP unconditionally. At that edge:
  - ALU_OUT/ZERO/EQUAL are latched into the RSP registers of the owner port only.
  - RSP_VALIDowner is set to 1.
- RESP → EXEC if a new request is accepted in RESP, otherwise → IDLE. RSP_VALID clears at the same edge.
- ALU_* registers hold their last values when not updated. The other port's RSP_OUT/flags hold their previous capture.
- REQ_VALID may be dropped before acceptance without penalty. Requesters must not make VALID depend on READY. READY depends combinationally on VALID.
- Operand changes after the accept edge do not affect the result.

## Timing
- Reset values:
  - state=IDLE, LAST_GRANT=1.
  - ALU_OP=0, ALU_A=0, ALU_B=0.
  - All RSP_VALID/OUT/ZERO/EQUAL=0.
  - BUSY=0.
  - REQ_READY outputs are 0 unless a VALID is high.
- Accept at edge E0. ALU inputs are valid from E0 and the ALU settles during the E0–E1 cycle.
- Capture at E1. RSP_VALID is high during E1–E2.
- Latency: accept edge to RSP_VALID rising is 1 cycle; the result is usable at edge E2.
- Peak throughput is one operation per 2 cycles, via back-to-back accept in RESP.
- With both ports continuously valid, grants alternate 0,1,0,1… every 2 cycles.
- Reset asserted mid-operation: immediate return to reset values. The in-flight result is discarded and no RSP_VALID is issued.

## Test plan
Bench ALU stub: OUT = OP0 ? A+B : A−B, ZERO = (OUT==0), EQUAL = (A==B).

- **Reset:** hold RESET_N=0 while both VALIDs are high → READY0=1 (combinational), BUSY=0, all RSP_VALID=0, ALU_A=ALU_B=0. RESET_N may be released asynchronously.
- **Single request, port 0:** OP=0, A=0x0004, B=0x0004 → READY0=1 for one cycle, BUSY=1 for one cycle, RSP_VALID0 pulses one cycle later with OUT=0x0008, ZERO=0, EQUAL=1. RSP_VALID1 stays 0.
- **Zero flag, port 1:** OP=1, A=0x0004, B=0x0004 → RSP_VALID1 pulse with OUT=0x0000, ZERO=1, EQUAL=1. Port 0 RSP registers are unchanged.
- **Contention:** both ports valid continuously with distinct operands (0x0004/0x0003 and 0x0010/0x0001) → grant order 0,1,0,1, a response every 2 cycles, each result on the correct port.
- **Back-to-back:** port 0 valid continuously, new operands each accept → accept in every RESP cycle, BUSY toggles 1,0,1,0, no dropped or duplicated responses.
- **Reset mid-op:** assert RESET_N=0 during EXEC → no RSP_VALID pulse, state IDLE, all RSP outputs 0 after release.
